// File: rtl/uart_bus_pkg.sv
// uart_bus_pkg
// Shared definitions for the UART-to-bus bridge:
//   - state_t    : main bridge FSM states
//   - sh_state_t : response shifter handshake states
//   - command / response byte constants
//   - BCNT_W     : width of the byte counters (frames carry 4-byte fields)
//   - byte_of()  : selects one byte of a 32-bit word, MSB first
package uart_bus_pkg;

    localparam int BCNT_W = 2;

    localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
    localparam logic [7:0] RESP_ACK  = 8'h4B;  // 'K'
    localparam logic [7:0] RESP_ERR  = 8'h3F;  // '?'

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GET_ADDR  = 3'd1,
        GET_DATA  = 3'd2,
        BUS_WR    = 3'd3,
        BUS_RD    = 3'd4,
        RD_WAIT   = 3'd5,
        SEND      = 3'd6,
        SEND_WAIT = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        SH_IDLE = 2'd0,
        SH_SEND = 2'd1,
        SH_WAIT = 2'd2
    } sh_state_t;

    // Index 0 is the most significant byte, so responses go out MSB first.
    function automatic logic [7:0] byte_of(input logic [31:0] w,
                                           input logic [BCNT_W-1:0] idx);
        case (idx)
            2'd0:    byte_of = w[31:24];
            2'd1:    byte_of = w[23:16];
            2'd2:    byte_of = w[15:8];
            default: byte_of = w[7:0];
        endcase
    endfunction

endpackage

// File: rtl/uart_bus_resp_shifter.sv
// uart_bus_resp_shifter
// Holds up to four response bytes and plays them out over the uart_tx byte
// interface, one Tx_DV pulse per byte, waiting for Tx_Done between bytes.
//
// Handshake: a byte is offered by pulsing o_tx_dv for one clock while the
// transmitter is not active; the byte on o_tx_byte then stays unchanged until
// the transmitter pulses i_tx_done. Only then is the next byte offered.
//
// Ports:
//   clk, reset    : clock, synchronous active-low reset
//   i_start       : load i_data / i_nbytes (accepted only when idle)
//   i_nbytes      : number of bytes to send, 1..4, taken from i_data[31:24] down
//   i_data        : response bytes, MSB first
//   i_tx_active   : transmitter busy
//   i_tx_done     : transmitter finished the current byte
//   o_tx_dv       : one-clock start pulse for the transmitter
//   o_tx_byte     : byte being offered / sent
//   o_done        : one-clock pulse when the last byte's Tx_Done arrives
module uart_bus_resp_shifter
    import uart_bus_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start,
    input  logic [BCNT_W:0]     i_nbytes,
    input  logic [31:0]         i_data,
    input  logic                i_tx_active,
    input  logic                i_tx_done,
    output logic                o_tx_dv,
    output logic [7:0]          o_tx_byte,
    output logic                o_done
);

    sh_state_t         r_state;
    sh_state_t         w_next;
    logic [31:0]       r_data;
    logic [BCNT_W-1:0] r_idx;
    logic [BCNT_W-1:0] r_last_idx;
    logic              w_last;
    logic              w_load;
    logic              w_advance;

    assign w_last    = (r_idx == r_last_idx);
    assign w_load    = i_start && (r_state == SH_IDLE);
    assign w_advance = (r_state == SH_WAIT) && i_tx_done && !w_last;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= SH_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Byte storage and pointer
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data     <= '0;
            r_idx      <= '0;
            r_last_idx <= '0;
        end else if (w_load) begin
            r_data     <= i_data;
            r_idx      <= '0;
            r_last_idx <= BCNT_W'(i_nbytes - 3'd1);
        end else if (w_advance) begin
            r_idx      <= r_idx + 1'b1;
        end
    end

    // Next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            SH_IDLE: if (i_start) w_next = SH_SEND;
            SH_SEND: if (!i_tx_active) w_next = SH_WAIT;
            SH_WAIT: begin
                if (i_tx_done) begin
                    w_next = w_last ? SH_IDLE : SH_SEND;
                end
            end
            default: w_next = SH_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        o_tx_dv   = (r_state == SH_SEND) && !i_tx_active;
        o_done    = (r_state == SH_WAIT) && i_tx_done && w_last;
        o_tx_byte = byte_of(r_data, r_idx);
    end

endmodule

// File: rtl/uart_bus_master.sv
// uart_bus_master
// Serial-to-bus bridge. Decodes byte frames from a uart_rx byte interface:
//   write: 'W' A3 A2 A1 A0 D3 D2 D1 D0  -> one MemWrite, reply 'K'
//   read : 'R' A3 A2 A1 A0              -> one MemRead,  reply D3 D2 D1 D0
//   other first byte                    -> Frame_Err pulse, reply '?'
// A frame that goes quiet for TIMEOUT_CLKS clocks mid-field is dropped with
// a Frame_Err pulse and no reply. The bridge is half-duplex: bytes arriving
// while a command executes or a reply is sent are discarded.
//
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   Rx_DV, Rx_Byte        : received byte strobe and value
//   Tx_DV, Tx_Byte        : transmit start pulse and byte (held until Tx_Done)
//   Tx_Active, Tx_Done    : transmitter status
//   MemRead, MemWrite     : one-clock bus strobes
//   Address, Write_data   : bus address / write data
//   Read_data             : bus read data, valid READ_LATENCY clocks after MemRead
//   Busy                  : state is not IDLE
//   Frame_Err             : one-clock pulse on bad command or timeout
module uart_bus_master #(
    parameter int         TIMEOUT_CLKS = 1_000_000,
    parameter int         READ_LATENCY = 1,
    parameter logic [7:0] CMD_WRITE    = uart_bus_pkg::CMD_WRITE,
    parameter logic [7:0] CMD_READ     = uart_bus_pkg::CMD_READ
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Rx_DV,
    input  logic [7:0]  Rx_Byte,
    output logic        Tx_DV,
    output logic [7:0]  Tx_Byte,
    input  logic        Tx_Active,
    input  logic        Tx_Done,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Address,
    output logic [31:0] Write_data,
    input  logic [31:0] Read_data,
    output logic        Busy,
    output logic        Frame_Err
);

    import uart_bus_pkg::*;

    localparam int TO_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;

    state_t            r_state;
    state_t            w_next;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [BCNT_W-1:0] r_byte_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [1:0]        r_lat_cnt;
    logic              r_is_write;
    logic              r_frame_err;

    logic              w_cmd_ok;
    logic              w_timeout;
    logic              w_lat_done;
    logic              w_in_field;
    logic              w_field_last;

    logic              w_mem_read;
    logic              w_mem_write;
    logic              w_busy;
    logic              w_fe_set;
    logic              w_sh_start;
    logic [BCNT_W:0]   w_sh_nbytes;
    logic [31:0]       w_sh_data;
    logic              w_sh_tx_dv;
    logic              w_sh_done;

    assign w_cmd_ok     = (Rx_Byte == CMD_WRITE) || (Rx_Byte == CMD_READ);
    assign w_in_field   = (r_state == GET_ADDR) || (r_state == GET_DATA);
    assign w_timeout    = (r_to_cnt == TO_W'(TIMEOUT_CLKS - 1));
    // The MemRead clock counts as the first latency clock, so RD_WAIT lasts
    // READ_LATENCY clocks and its final clock sees valid Read_data.
    assign w_lat_done   = (r_lat_cnt == 2'(READ_LATENCY - 1));
    assign w_field_last = (r_byte_cnt == 2'd3);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (Rx_DV) w_next = w_cmd_ok ? GET_ADDR : SEND;
            end
            GET_ADDR: begin
                if (Rx_DV) begin
                    if (w_field_last) w_next = r_is_write ? GET_DATA : BUS_RD;
                end else if (w_timeout) begin
                    w_next = IDLE;
                end
            end
            GET_DATA: begin
                if (Rx_DV) begin
                    if (w_field_last) w_next = BUS_WR;
                end else if (w_timeout) begin
                    w_next = IDLE;
                end
            end
            BUS_WR:    w_next = SEND;
            BUS_RD:    w_next = RD_WAIT;
            RD_WAIT:   if (w_lat_done) w_next = SEND;
            SEND:      if (w_sh_tx_dv) w_next = SEND_WAIT;
            SEND_WAIT: begin
                if (w_sh_done)    w_next = IDLE;
                else if (Tx_Done) w_next = SEND;
            end
            default:   w_next = IDLE;
        endcase
    end

    // Outputs and reply loading
    always_comb begin
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_busy      = (r_state != IDLE);
        w_fe_set    = 1'b0;
        w_sh_start  = 1'b0;
        w_sh_nbytes = 3'd1;
        w_sh_data   = '0;
        case (r_state)
            IDLE: begin
                if (Rx_DV && !w_cmd_ok) begin
                    w_fe_set   = 1'b1;
                    w_sh_start = 1'b1;
                    w_sh_data  = {RESP_ERR, 24'h0};
                end
            end
            GET_ADDR, GET_DATA: begin
                if (!Rx_DV && w_timeout) w_fe_set = 1'b1;
            end
            BUS_WR: begin
                w_mem_write = 1'b1;
                w_sh_start  = 1'b1;
                w_sh_data   = {RESP_ACK, 24'h0};
            end
            BUS_RD: w_mem_read = 1'b1;
            RD_WAIT: begin
                // Read_data goes straight into the shifter, which serves as
                // the response register.
                if (w_lat_done) begin
                    w_sh_start  = 1'b1;
                    w_sh_nbytes = 3'd4;
                    w_sh_data   = Read_data;
                end
            end
            default: ;
        endcase
    end

    // Frame datapath: field shifting, byte counter, timeout and latency counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_byte_cnt  <= '0;
            r_to_cnt    <= '0;
            r_lat_cnt   <= '0;
            r_is_write  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_fe_set;

            if (r_state == IDLE && Rx_DV && w_cmd_ok) begin
                r_is_write <= (Rx_Byte == CMD_WRITE);
                r_byte_cnt <= '0;
            end else if (w_in_field && Rx_DV) begin
                // Wraps 3 -> 0, so the data field starts counting from zero.
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end

            if (r_state == GET_ADDR && Rx_DV) r_addr  <= {r_addr[23:0], Rx_Byte};
            if (r_state == GET_DATA && Rx_DV) r_wdata <= {r_wdata[23:0], Rx_Byte};

            if (w_in_field && !Rx_DV && !w_timeout) r_to_cnt <= r_to_cnt + 1'b1;
            else                                    r_to_cnt <= '0;

            if (r_state == RD_WAIT) r_lat_cnt <= r_lat_cnt + 1'b1;
            else                    r_lat_cnt <= '0;
        end
    end

    uart_bus_resp_shifter u_resp (
        .clk         (clk),
        .reset       (reset),
        .i_start     (w_sh_start),
        .i_nbytes    (w_sh_nbytes),
        .i_data      (w_sh_data),
        .i_tx_active (Tx_Active),
        .i_tx_done   (Tx_Done),
        .o_tx_dv     (w_sh_tx_dv),
        .o_tx_byte   (Tx_Byte),
        .o_done      (w_sh_done)
    );

    assign Tx_DV      = w_sh_tx_dv;
    assign MemRead    = w_mem_read;
    assign MemWrite   = w_mem_write;
    assign Address    = r_addr;
    assign Write_data = r_wdata;
    assign Busy       = w_busy;
    assign Frame_Err  = r_frame_err;

endmodule

// File: tb/tb_uart_bus_master.sv
// tb_uart_bus_master
// Drives byte frames into uart_bus_master, models the transmitter and a
// memory that answers reads, and checks bus strobes and reply bytes against
// expected queues filled when each frame is issued.
module tb_uart_bus_master;

    localparam int TO_CLKS = 100;
    localparam int RL      = 1;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Rx_DV = 1'b0;
    logic [7:0]  Rx_Byte = 8'h00;
    logic        Tx_DV;
    logic [7:0]  Tx_Byte;
    logic        Tx_Active = 1'b0;
    logic        Tx_Done = 1'b0;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic [31:0] Read_data = 32'h0;
    logic        Busy;
    logic        Frame_Err;

    always #5 clk = ~clk;

    uart_bus_master #(
        .TIMEOUT_CLKS (TO_CLKS),
        .READ_LATENCY (RL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Rx_DV      (Rx_DV),
        .Rx_Byte    (Rx_Byte),
        .Tx_DV      (Tx_DV),
        .Tx_Byte    (Tx_Byte),
        .Tx_Active  (Tx_Active),
        .Tx_Done    (Tx_Done),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Address    (Address),
        .Write_data (Write_data),
        .Read_data  (Read_data),
        .Busy       (Busy),
        .Frame_Err  (Frame_Err)
    );

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [7:0]  exp_tx_q[$];
    logic [65:0] exp_bus_q[$];   // {MemWrite, MemRead, Address, Write_data or 0}
    int          fe_cnt = 0;
    int          mr_cnt = 0;
    int          mw_cnt = 0;
    int          tx_cnt = 0;
    logic        tx_in_flight = 1'b0;
    logic [7:0]  tx_hold = 8'h00;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (a == 32'h4000_0020) return 32'hDEAD_BEEF;
        return (a ^ 32'hA5C3_0F69) + 32'h0000_1357;
    endfunction

    // ---------------- transmitter model ----------------
    initial begin : tx_model
        forever begin
            @(negedge clk);
            if (Tx_DV) begin
                @(posedge clk); #1 Tx_Active = 1'b1;
                repeat (3) @(posedge clk);
                #1 Tx_Active = 1'b0; Tx_Done = 1'b1;
                @(posedge clk); #1 Tx_Done = 1'b0;
            end
        end
    end

    // ---------------- bus memory model ----------------
    initial begin : bus_model
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (MemRead) begin
                a = Address;
                repeat (RL) @(posedge clk);
                #1 Read_data = rd_model(a);
                @(posedge clk);
                #1 Read_data = 32'h0;
            end
        end
    end

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        logic [65:0] got_bus;
        logic [65:0] exp_bus;
        logic [7:0]  exp_b;
        if (!reset) begin
            tx_in_flight = 1'b0;
        end else begin
            if (Frame_Err) fe_cnt++;
            if (MemRead)   mr_cnt++;
            if (MemWrite)  mw_cnt++;
            if (MemRead || MemWrite) begin
                got_bus = {MemWrite, MemRead, Address, (MemWrite ? Write_data : 32'h0)};
                n_cmp++;
                if (exp_bus_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL bus_strobe: got unexpected strobe %h, required none", got_bus);
                end else begin
                    exp_bus = exp_bus_q.pop_front();
                    if (got_bus !== exp_bus) begin
                        n_mis++;
                        $display("FAIL bus_strobe: got %h required %h", got_bus, exp_bus);
                    end
                end
            end
            if (Tx_DV) begin
                tx_cnt++;
                n_cmp++;
                if (tx_in_flight) begin
                    n_mis++;
                    $display("FAIL tx_overlap: Tx_DV=1 before Tx_Done, required wait");
                end
                n_cmp++;
                if (exp_tx_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL tx_byte: got unexpected byte %h, required none", Tx_Byte);
                end else begin
                    exp_b = exp_tx_q.pop_front();
                    if (Tx_Byte !== exp_b) begin
                        n_mis++;
                        $display("FAIL tx_byte: got %h required %h", Tx_Byte, exp_b);
                    end
                end
                tx_in_flight = 1'b1;
                tx_hold      = Tx_Byte;
            end else if (tx_in_flight) begin
                n_cmp++;
                if (Tx_Byte !== tx_hold) begin
                    n_mis++;
                    $display("FAIL tx_hold: got %h required %h until Tx_Done", Tx_Byte, tx_hold);
                end
                if (Tx_Done) tx_in_flight = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_rx_byte(input logic [7:0] b);
        @(negedge clk);
        Rx_DV   = 1'b1;
        Rx_Byte = b;
        @(negedge clk);
        Rx_DV   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!Busy && !tx_in_flight && exp_tx_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!ok) begin
            n_mis++;
            $display("FAIL %s_idle: got Busy=%0b pending_tx=%0d, required idle with none pending",
                     tag, Busy, exp_tx_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({Busy, Tx_DV, MemRead, MemWrite, Frame_Err} !== 5'b0) begin
            n_mis++;
            $display("FAIL reset_flags: got %b required 00000", {Busy, Tx_DV, MemRead, MemWrite, Frame_Err});
        end
        n_cmp++;
        if (Address !== 32'h0) begin
            n_mis++; $display("FAIL reset_addr: got %h required 0", Address);
        end
        n_cmp++;
        if (Write_data !== 32'h0) begin
            n_mis++; $display("FAIL reset_wdata: got %h required 0", Write_data);
        end
        n_cmp++;
        if (Tx_Byte !== 8'h0) begin
            n_mis++; $display("FAIL reset_txbyte: got %h required 0", Tx_Byte);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write(input logic [31:0] addr, input logic [31:0] data);
        int mw0, tx0;
        mw0 = mw_cnt;
        tx0 = tx_cnt;
        exp_bus_q.push_back({1'b1, 1'b0, addr, data});
        exp_tx_q.push_back(8'h4B);
        drive_rx_byte(8'h57);
        for (int i = 3; i >= 0; i--) drive_rx_byte(addr[8*i +: 8]);
        for (int i = 3; i >= 0; i--) drive_rx_byte(data[8*i +: 8]);
        n_cmp++;
        if (MemWrite !== 1'b1 || MemRead !== 1'b0) begin
            n_mis++;
            $display("FAIL write_strobe_lat: got MemWrite=%b MemRead=%b required 1/0 one clock after last byte",
                     MemWrite, MemRead);
        end
        @(negedge clk);
        n_cmp++;
        if (Tx_DV !== 1'b1 || Tx_Byte !== 8'h4B) begin
            n_mis++;
            $display("FAIL write_ack_lat: got Tx_DV=%b Tx_Byte=%h required 1/4b", Tx_DV, Tx_Byte);
        end
        wait_idle("write");
        n_cmp++;
        if (mw_cnt - mw0 !== 1 || tx_cnt - tx0 !== 1) begin
            n_mis++;
            $display("FAIL write_counts: got writes=%0d tx=%0d required 1/1", mw_cnt - mw0, tx_cnt - tx0);
        end
    endtask

    task automatic test_read(input logic [31:0] addr);
        int mr0, tx0;
        logic [31:0] rd;
        mr0 = mr_cnt;
        tx0 = tx_cnt;
        rd  = rd_model(addr);
        exp_bus_q.push_back({1'b0, 1'b1, addr, 32'h0});
        for (int i = 3; i >= 0; i--) exp_tx_q.push_back(rd[8*i +: 8]);
        drive_rx_byte(8'h52);
        for (int i = 3; i >= 0; i--) drive_rx_byte(addr[8*i +: 8]);
        n_cmp++;
        if (MemRead !== 1'b1 || MemWrite !== 1'b0) begin
            n_mis++;
            $display("FAIL read_strobe_lat: got MemRead=%b MemWrite=%b required 1/0 one clock after last byte",
                     MemRead, MemWrite);
        end
        repeat (RL) @(negedge clk);
        n_cmp++;
        if (Tx_DV !== 1'b0) begin
            n_mis++; $display("FAIL read_early_tx: got Tx_DV=%b required 0", Tx_DV);
        end
        @(negedge clk);
        n_cmp++;
        if (Tx_DV !== 1'b1) begin
            n_mis++; $display("FAIL read_tx_lat: got Tx_DV=%b required 1", Tx_DV);
        end
        wait_idle("read");
        n_cmp++;
        if (mr_cnt - mr0 !== 1 || tx_cnt - tx0 !== 4) begin
            n_mis++;
            $display("FAIL read_counts: got reads=%0d tx=%0d required 1/4", mr_cnt - mr0, tx_cnt - tx0);
        end
    endtask

    task automatic test_bad_cmd();
        int fe0, mr0, mw0;
        fe0 = fe_cnt; mr0 = mr_cnt; mw0 = mw_cnt;
        exp_tx_q.push_back(8'h3F);
        drive_rx_byte(8'h41);
        n_cmp++;
        if (Frame_Err !== 1'b1 || Tx_DV !== 1'b1) begin
            n_mis++;
            $display("FAIL badcmd_resp: got Frame_Err=%b Tx_DV=%b required 1/1", Frame_Err, Tx_DV);
        end
        wait_idle("badcmd");
        n_cmp++;
        if (fe_cnt - fe0 !== 1 || mr_cnt != mr0 || mw_cnt != mw0) begin
            n_mis++;
            $display("FAIL badcmd_counts: got fe=%0d rd=%0d wr=%0d required 1/0/0",
                     fe_cnt - fe0, mr_cnt - mr0, mw_cnt - mw0);
        end
    endtask

    task automatic test_timeout();
        int fe0, mr0, mw0, tx0;
        fe0 = fe_cnt; mr0 = mr_cnt; mw0 = mw_cnt; tx0 = tx_cnt;
        drive_rx_byte(8'h57);
        drive_rx_byte(8'h40);
        drive_rx_byte(8'h00);
        repeat (TO_CLKS - 1) @(negedge clk);
        n_cmp++;
        if (Busy !== 1'b1 || Frame_Err !== 1'b0) begin
            n_mis++;
            $display("FAIL timeout_early: got Busy=%b Frame_Err=%b required 1/0", Busy, Frame_Err);
        end
        @(negedge clk);
        n_cmp++;
        if (Busy !== 1'b0 || Frame_Err !== 1'b1) begin
            n_mis++;
            $display("FAIL timeout_fire: got Busy=%b Frame_Err=%b required 0/1", Busy, Frame_Err);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (fe_cnt - fe0 !== 1 || mr_cnt != mr0 || mw_cnt != mw0 || tx_cnt != tx0) begin
            n_mis++;
            $display("FAIL timeout_counts: got fe=%0d rd=%0d wr=%0d tx=%0d required 1/0/0/0",
                     fe_cnt - fe0, mr_cnt - mr0, mw_cnt - mw0, tx_cnt - tx0);
        end
        test_write(32'h1234_5678, 32'h9ABC_DEF0);
    endtask

    task automatic test_reset_mid_read();
        int tx0;
        tx0 = tx_cnt;
        exp_bus_q.push_back({1'b0, 1'b1, 32'h4000_0010, 32'h0});
        drive_rx_byte(8'h52);
        drive_rx_byte(8'h40);
        drive_rx_byte(8'h00);
        drive_rx_byte(8'h00);
        drive_rx_byte(8'h10);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({Busy, Tx_DV, MemRead, MemWrite, Frame_Err} !== 5'b0 || Address !== 32'h0 || Tx_Byte !== 8'h0) begin
            n_mis++;
            $display("FAIL midreset_outputs: got flags=%b addr=%h txb=%h required all zero",
                     {Busy, Tx_DV, MemRead, MemWrite, Frame_Err}, Address, Tx_Byte);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (tx_cnt != tx0) begin
            n_mis++; $display("FAIL midreset_tx: got %0d Tx_DV pulses required 0", tx_cnt - tx0);
        end
        test_read(32'h4000_0018);
    endtask

    task automatic test_rx_during_send();
        int mr0, mw0, fe0;
        bit seen;
        logic [31:0] addr, rd;
        addr = 32'h4000_0030;
        rd   = rd_model(addr);
        mr0 = mr_cnt; mw0 = mw_cnt; fe0 = fe_cnt;
        exp_bus_q.push_back({1'b0, 1'b1, addr, 32'h0});
        for (int i = 3; i >= 0; i--) exp_tx_q.push_back(rd[8*i +: 8]);
        drive_rx_byte(8'h52);
        for (int i = 3; i >= 0; i--) drive_rx_byte(addr[8*i +: 8]);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (Tx_DV) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!seen) begin
            n_mis++; $display("FAIL rxsend_first_tx: got no Tx_DV within 20 clocks, required one");
        end
        @(negedge clk); Rx_DV = 1'b1; Rx_Byte = 8'h57;
        @(negedge clk); Rx_Byte = 8'h52;
        @(negedge clk); Rx_Byte = 8'h41;
        @(negedge clk); Rx_DV = 1'b0;
        wait_idle("rxsend");
        repeat (5) @(negedge clk);
        n_cmp++;
        if (mr_cnt - mr0 !== 1 || mw_cnt != mw0 || fe_cnt != fe0 || Busy !== 1'b0) begin
            n_mis++;
            $display("FAIL rxsend_ignored: got rd=%0d wr=%0d fe=%0d Busy=%b required 1/0/0/0",
                     mr_cnt - mr0, mw_cnt - mw0, fe_cnt - fe0, Busy);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 1) == 1) test_write($urandom, $urandom);
            else                           test_read($urandom);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_write(32'h4000_000C, 32'h0000_00FF);
        test_read(32'h4000_0020);
        test_bad_cmd();
        test_timeout();
        test_reset_mid_read();
        test_rx_during_send();
        test_back_to_back();
        repeat (5) @(negedge clk);
        n_cmp++;
        if (exp_tx_q.size() != 0 || exp_bus_q.size() != 0) begin
            n_mis++;
            $display("FAIL leftover_expected: got tx=%0d bus=%0d unconsumed, required 0/0",
                     exp_tx_q.size(), exp_bus_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within 500000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
